stats_csr_initiator_avlstrm: RTL

//  Host-side initiator for the stats register file's request/response streams.

---
 rtl/stats_csr_initiator_avlstrm_if.sv | 14 +
 rtl/stats_csr_initiator_avlstrm.sv | 104 ++++++++++
 2 files changed

// File: rtl/stats_csr_initiator_avlstrm_if.sv
// Single-beat streaming channel between the host-side CSR initiator and the stats responder.
// tx drives valid/data/sop/eop and receives ready; rx is the mirror image.
interface avl_stream_if #(
  parameter int DW = 32
);
  logic          valid;
  logic          ready;
  logic          sop;
  logic          eop;
  logic [DW-1:0] data;

  modport tx (output valid, sop, eop, data, input ready);
  modport rx (input valid, sop, eop, data, output ready);
endinterface

// File: rtl/stats_csr_initiator_avlstrm.sv
// Host CSR initiator: turns one outstanding Avalon-MM read/write into stats request stream
// beats and returns the read response, or TIMEOUT_DATA if the responder never answers.
module stats_csr_initiator_avlstrm #(
  parameter int          TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] TIMEOUT_DATA   = 32'hDEAD_BEEF
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [29:0] host_address,
  input  logic        host_read,
  input  logic        host_write,
  input  logic [31:0] host_writedata,
  output logic        host_waitrequest,
  output logic [31:0] host_readdata,
  output logic        host_readdatavalid,
  avl_stream_if.tx    stats_wr_req,
  avl_stream_if.tx    stats_rd_req,
  avl_stream_if.rx    stats_rd_resp,
  output logic [15:0] timeout_cnt,
  output logic [15:0] stray_cnt
);

  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

  typedef enum logic [1:0] {IDLE, WR_REQ, RD_REQ, RD_WAIT} state_t;

  state_t        state;
  logic [TW-1:0] timer;
  logic          unused_ok;

  assign host_waitrequest    = Rst | (state != IDLE);
  assign stats_rd_resp.ready = 1'b1;
  assign stats_wr_req.sop    = stats_wr_req.valid;
  assign stats_wr_req.eop    = stats_wr_req.valid;
  assign stats_rd_req.sop    = stats_rd_req.valid;
  assign stats_rd_req.eop    = stats_rd_req.valid;
  assign unused_ok           = &{1'b0, stats_rd_resp.sop, stats_rd_resp.eop};

  // NOTE: all state below is updated with non-blocking assignments so every
  // branch sees the pre-edge values of state, timer and the counters.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state              <= IDLE;
      timer              <= '0;
      host_readdata      <= '0;
      host_readdatavalid <= 1'b0;
      timeout_cnt        <= '0;
      stray_cnt          <= '0;
      stats_wr_req.valid <= 1'b0;
      stats_wr_req.data  <= '0;
      stats_rd_req.valid <= 1'b0;
      stats_rd_req.data  <= '0;
    end else begin
      host_readdatavalid <= 1'b0;

      // Any response outside RD_WAIT has no owner and is only counted.
      if (stats_rd_resp.valid && state != RD_WAIT && stray_cnt != 16'hFFFF)
        stray_cnt <= stray_cnt + 16'd1;

      case (state)
        IDLE: begin
          if (host_write) begin
            stats_wr_req.valid <= 1'b1;
            stats_wr_req.data  <= {host_address, host_writedata};
            state              <= WR_REQ;
          end else if (host_read) begin
            stats_rd_req.valid <= 1'b1;
            stats_rd_req.data  <= host_address;
            state              <= RD_REQ;
          end
        end
        WR_REQ: begin
          if (stats_wr_req.ready) begin
            stats_wr_req.valid <= 1'b0;
            state              <= IDLE;
          end
        end
        RD_REQ: begin
          if (stats_rd_req.ready) begin
            stats_rd_req.valid <= 1'b0;
            timer              <= '0;
            state              <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          timer <= timer + 1'b1;
          if (stats_rd_resp.valid) begin
            host_readdata      <= stats_rd_resp.data;
            host_readdatavalid <= 1'b1;
            state              <= IDLE;
          end else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
            host_readdata      <= TIMEOUT_DATA;
            host_readdatavalid <= 1'b1;
            if (timeout_cnt != 16'hFFFF)
              timeout_cnt <= timeout_cnt + 16'd1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
